fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Program-counter sequencer and fetch controller for the instruction memory. It drives the memory's word-indexed read address and accounts for the memory's one-cycle registered read latency. It presents each fetched instruction with its byte PC to the decode stage. It supports downstream stall, branch/jump redirect, and a halt on an all-zero word, an end of memory, or an illegal redirect target.

## Interface
- DEPTH, 32: number of 32-bit words in instruction memory; legal word indices are 0..DEPTH-1.
- CNT_W, 16: width of the delivered-instruction counter.
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- mem_addr  out  32  word index presented to instruction memory; combinational from state and inputs.
- mem_instr  in  32  memory read data; holds the word at the index sampled on the previous rising edge.
- stall  in  1  decode cannot accept this cycle.
- redirect_valid  in  1  change fetch stream.
- redirect_pc  in  32  byte target address of the redirect.
- if_valid  out  1  if_instr/if_pc valid this cycle.
- if_pc  out  32  byte PC of if_instr.
- if_instr  out  32  fetched instruction; equals mem_instr.
- halted  out  1  sequencer stopped; cleared only by reset.
- error  out  1  halt was caused by an illegal redirect target.
- fetch_count  out  CNT_W  number of delivered instructions, saturating.

## Operation
- Internal registers:
  - state ∈ {BOOT, RUN, HALT}.
  - resp_pc (32 bits): byte PC of the word currently on mem_instr.
  - resp_valid: mem_instr holds a requested word.
- Reset values: state=BOOT, resp_pc=0, resp_valid=0, halted=0, error=0, fetch_count=0. Outputs during and right after reset: if_valid=0, if_pc=0, mem_addr=0.
- The memory loads its contents while reset is high and does not update its output until reset is low. The sequencer therefore issues nothing until the BOOT cycle.
- BOOT (first cycle after reset release):
  - mem_addr=0.
  - Next state: RUN, with resp_pc=0 and resp_valid=1.
- RUN: if_valid = resp_valid && mem_instr != 0; if_pc=resp_pc; if_instr=mem_instr. Priority, highest first:
  1. redirect_valid: if redirect_pc[1:0] != 0 or redirect_pc[31:2] >= DEPTH, go to HALT with error=1 and resp_valid=0. Otherwise mem_addr = redirect_pc>>2, resp_pc <= redirect_pc, resp_valid <= 1. The word displayed this cycle is squashed and not counted. Redirect wins over stall.
  2. resp_valid && mem_instr == 0: halt marker. Go to HALT with error=0. The word is not delivered.
  3. stall: mem_addr = resp_pc>>2 (replay, so mem_instr stays stable). All registers hold.
  4. Otherwise the word is delivered and fetch_count increments, saturating at 2^CNT_W−1. The next PC is resp_pc+4.
     - If (resp_pc>>2)+1 >= DEPTH: go to HALT with error=0. There is no wrap-around.
     - Else mem_addr = next>>2 and resp_pc <= next.
- HALT:
  - if_valid=0, halted=1.
  - mem_addr holds resp_pc>>2.
  - redirect_valid and stall are ignored. Only reset exits HALT.
- Reset asserted in any state, including mid-stall or mid-redirect, returns to the reset values on the next edge. Any in-flight word is discarded.

## Timing
- Fetch latency is 1 cycle: an index presented on mem_addr in cycle N appears as if_instr in cycle N+1.
- Sustained throughput is 1 instruction per cycle with no stalls.
- First if_valid is the second cycle after reset deasserts, with if_pc=0.
- Redirect asserted in cycle N gives if_valid with if_pc=redirect_pc in cycle N+1, a 0-bubble redirect.
- Halt detected in cycle N: halted=1 from cycle N+1. if_valid is already 0 in cycle N for a zero-word halt.
- Stall for k cycles holds if_valid, if_pc, and if_instr constant for k+1 cycles, counting the accepting cycle.
- fetch_count updates on the edge ending the delivery cycle.

## Test plan
- Memory words 0..15 nonzero, word 16 zero; no stall:
  - if_pc = 0,4,…,60 on 16 consecutive cycles from cycle 2 after reset.
  - Then halted=1, error=0, fetch_count=16.
- Same program, stall high for 3 cycles while if_pc=8:
  - if_pc=8 and if_instr=word2 held for 4 cycles, then 12 follows.
  - Final fetch_count=16.
- Redirect to 0x0C while if_pc=0x20:
  - Next cycle if_pc=0x0C.
  - Word 8 is not counted; delivery continues 0x10, 0x14, ….
- Redirect to 0x82 (misaligned), and separately to 0x80 (index 32 ≥ DEPTH):
  - Next cycle if_valid=0, halted=1, error=1.
  - Subsequent redirects and stalls have no effect.
- All 32 words nonzero:
  - Last delivered if_pc=124.
  - Then halted=1, error=0, fetch_count=32, and mem_addr never exceeds 31.
- Reset pulsed while if_pc=0x18 with stall high:
  - Outputs return to reset values.
  - Sequence restarts with if_pc=0 two cycles after release; fetch_count restarts at 0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Program-counter sequencer and fetch controller for a word-indexed instruction memory
// with a one-cycle registered read. Delivers instructions with their byte PC to decode.
module fetch_sequencer #(
   parameter int DEPTH = 32,
   parameter int CNT_W = 16
) (
   input  logic             clock,
   input  logic             reset,
   output logic [31:0]      mem_addr,
   input  logic [31:0]      mem_instr,
   input  logic             stall,
   input  logic             redirect_valid,
   input  logic [31:0]      redirect_pc,
   output logic             if_valid,
   output logic [31:0]      if_pc,
   output logic [31:0]      if_instr,
   output logic             halted,
   output logic             error,
   output logic [CNT_W-1:0] fetch_count
);

   localparam logic [1:0] BOOT = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] HALT = 2'd2;

   localparam logic [31:0] DEPTH_W = 32'(DEPTH);

   logic [1:0]       state_reg, state_next;
   logic [31:0]      resp_pc_reg, resp_pc_next;
   logic             resp_valid_reg, resp_valid_next;
   logic             error_reg, error_next;
   logic [CNT_W-1:0] fetch_count_reg, fetch_count_next;

   logic [31:0] resp_idx;
   logic [31:0] next_idx;
   logic [31:0] redirect_idx;
   logic        redirect_bad;
   logic        zero_word;

   assign resp_idx     = {2'b00, resp_pc_reg[31:2]};
   assign next_idx     = resp_idx + 32'd1;
   assign redirect_idx = {2'b00, redirect_pc[31:2]};
   assign redirect_bad = (redirect_pc[1:0] != 2'b00) || (redirect_idx >= DEPTH_W);
   assign zero_word    = resp_valid_reg && (mem_instr == 32'd0);

   always_comb begin
      state_next       = state_reg;
      resp_pc_next     = resp_pc_reg;
      resp_valid_next  = resp_valid_reg;
      error_next       = error_reg;
      fetch_count_next = fetch_count_reg;
      // Default re-presents the current word so mem_instr stays stable (stall, halt).
      mem_addr         = resp_idx;

      case (state_reg)
         BOOT: begin
            mem_addr        = 32'd0;
            state_next      = RUN;
            resp_pc_next    = 32'd0;
            resp_valid_next = 1'b1;
         end
         RUN: begin
            if (redirect_valid) begin
               if (redirect_bad) begin
                  state_next      = HALT;
                  error_next      = 1'b1;
                  resp_valid_next = 1'b0;
               end else begin
                  mem_addr        = redirect_idx;
                  resp_pc_next    = redirect_pc;
                  resp_valid_next = 1'b1;
               end
            end else if (zero_word) begin
               state_next = HALT;
            end else if (!stall) begin
               if (resp_valid_reg) begin
                  if (fetch_count_reg != {CNT_W{1'b1}})
                     fetch_count_next = fetch_count_reg + CNT_W'(1);
                  // No wrap-around: running off the end of memory halts cleanly.
                  if (next_idx >= DEPTH_W) begin
                     state_next = HALT;
                  end else begin
                     mem_addr     = next_idx;
                     resp_pc_next = resp_pc_reg + 32'd4;
                  end
               end else begin
                  resp_valid_next = 1'b1;
               end
            end
         end
         default: begin
         end
      endcase

      if (reset)
         mem_addr = 32'd0;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg       <= BOOT;
         resp_pc_reg     <= 32'd0;
         resp_valid_reg  <= 1'b0;
         error_reg       <= 1'b0;
         fetch_count_reg <= '0;
      end else begin
         state_reg       <= state_next;
         resp_pc_reg     <= resp_pc_next;
         resp_valid_reg  <= resp_valid_next;
         error_reg       <= error_next;
         fetch_count_reg <= fetch_count_next;
      end
   end

   assign if_valid    = !reset && (state_reg == RUN) && resp_valid_reg && (mem_instr != 32'd0);
   assign if_pc       = reset ? 32'd0 : resp_pc_reg;
   assign if_instr    = mem_instr;
   assign halted      = (state_reg == HALT);
   assign error       = error_reg;
   assign fetch_count = fetch_count_reg;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a registered-read instruction memory model.
// Inputs change just after the falling edge; outputs are sampled at the falling edge.
module tb_fetch_sequencer;

   logic        clock;
   logic        reset;
   logic [31:0] mem_addr;
   logic [31:0] mem_instr;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic        halted;
   logic        error;
   logic [15:0] fetch_count;

   logic [31:0] mem [0:31];
   logic        addr_over;
   int          checks;
   int          errors;

   fetch_sequencer #(.DEPTH(32), .CNT_W(16)) dut (
      .clock          (clock),
      .reset          (reset),
      .mem_addr       (mem_addr),
      .mem_instr      (mem_instr),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .if_valid       (if_valid),
      .if_pc          (if_pc),
      .if_instr       (if_instr),
      .halted         (halted),
      .error          (error),
      .fetch_count    (fetch_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Memory holds its output while reset is high.
   always @(posedge clock) begin
      if (!reset)
         mem_instr <= (mem_addr < 32'd32) ? mem[mem_addr[4:0]] : 32'hBAD0_0000;
   end

   always @(negedge clock) begin
      if (!reset && mem_addr > 32'd31)
         addr_over <= 1'b1;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] word(input int k);
      return 32'hC0DE_0000 + 32'(k);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clock);
   endtask

   task automatic load(input int n);
      for (int i = 0; i < 32; i++)
         mem[i] = (i < n) ? word(i) : 32'd0;
   endtask

   // Leaves the bench in the first RUN cycle (if_pc should be 0).
   task automatic release_reset();
      reset          = 1'b1;
      stall          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'd0;
      step();
      step();
      check("rst_if_valid", {31'd0, if_valid}, 32'd0);
      check("rst_if_pc", if_pc, 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_halted", {31'd0, halted}, 32'd0);
      check("rst_error", {31'd0, error}, 32'd0);
      check("rst_count", {16'd0, fetch_count}, 32'd0);
      reset = 1'b0;
      #1;
      check("boot_mem_addr", mem_addr, 32'd0);
      check("boot_if_valid", {31'd0, if_valid}, 32'd0);
      step();
   endtask

   task automatic expect_word(input string tag, input int k, input int cnt);
      check({tag, "_valid"}, {31'd0, if_valid}, 32'd1);
      check({tag, "_pc"}, if_pc, 32'(4 * k));
      check({tag, "_instr"}, if_instr, word(k));
      check({tag, "_count"}, {16'd0, fetch_count}, 32'(cnt));
   endtask

   task automatic run_to_halt();
      for (int i = 0; i < 64 && !halted; i++)
         step();
      check("halt_reached", {31'd0, halted}, 32'd1);
   endtask

   initial begin
      checks         = 0;
      errors         = 0;
      addr_over      = 1'b0;
      mem_instr      = 32'd0;
      reset          = 1'b1;
      stall          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'd0;

      // Straight-line program ending on a zero word at index 16.
      load(16);
      release_reset();
      for (int k = 0; k < 16; k++) begin
         expect_word("seq", k, k);
         step();
      end
      check("zero_if_valid", {31'd0, if_valid}, 32'd0);
      check("zero_if_pc", if_pc, 32'd64);
      check("zero_halted_early", {31'd0, halted}, 32'd0);
      step();
      check("seq_halted", {31'd0, halted}, 32'd1);
      check("seq_error", {31'd0, error}, 32'd0);
      check("seq_count", {16'd0, fetch_count}, 32'd16);
      check("seq_halt_addr", mem_addr, 32'd16);
      $display("test straight_line: count=%0d halted=%0b", fetch_count, halted);

      // Stall three cycles while if_pc=8.
      release_reset();
      expect_word("st_pre0", 0, 0);
      step();
      expect_word("st_pre1", 1, 1);
      step();
      stall = 1'b1;
      for (int j = 0; j < 3; j++) begin
         expect_word("st_hold", 2, 2);
         #1;
         check("st_replay_addr", mem_addr, 32'd2);
         step();
      end
      stall = 1'b0;
      expect_word("st_accept", 2, 2);
      step();
      expect_word("st_after", 3, 3);
      run_to_halt();
      check("st_count", {16'd0, fetch_count}, 32'd16);
      $display("test stall: count=%0d", fetch_count);

      // Redirect to 0x0C while if_pc=0x20.
      release_reset();
      for (int k = 0; k < 8; k++)
         step();
      expect_word("rd_at20", 8, 8);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_000C;
      #1;
      check("rd_mem_addr", mem_addr, 32'd3);
      step();
      redirect_valid = 1'b0;
      expect_word("rd_target", 3, 8);
      step();
      expect_word("rd_next1", 4, 9);
      step();
      expect_word("rd_next2", 5, 10);
      run_to_halt();
      check("rd_count", {16'd0, fetch_count}, 32'd21);
      $display("test redirect: count=%0d", fetch_count);

      // Illegal redirect targets: misaligned, then out of range.
      for (int t = 0; t < 2; t++) begin
         release_reset();
         step();
         step();
         expect_word("bad_pre", 2, 2);
         redirect_valid = 1'b1;
         redirect_pc    = (t == 0) ? 32'h0000_0082 : 32'h0000_0080;
         step();
         redirect_valid = 1'b0;
         check("bad_if_valid", {31'd0, if_valid}, 32'd0);
         check("bad_halted", {31'd0, halted}, 32'd1);
         check("bad_error", {31'd0, error}, 32'd1);
         redirect_valid = 1'b1;
         redirect_pc    = 32'h0000_0010;
         stall          = 1'b1;
         for (int j = 0; j < 3; j++)
            step();
         redirect_valid = 1'b0;
         stall          = 1'b0;
         check("bad_stay_halted", {31'd0, halted}, 32'd1);
         check("bad_stay_error", {31'd0, error}, 32'd1);
         check("bad_stay_valid", {31'd0, if_valid}, 32'd0);
         check("bad_stay_count", {16'd0, fetch_count}, 32'd2);
         check("bad_stay_addr", mem_addr, 32'd2);
         $display("test bad_redirect %0d: halted=%0b error=%0b", t, halted, error);
      end

      // Every word nonzero: halt at the end of memory without wrapping.
      load(32);
      release_reset();
      for (int k = 0; k < 32; k++) begin
         expect_word("full", k, k);
         step();
      end
      check("full_halted", {31'd0, halted}, 32'd1);
      check("full_error", {31'd0, error}, 32'd0);
      check("full_count", {16'd0, fetch_count}, 32'd32);
      check("full_if_valid", {31'd0, if_valid}, 32'd0);
      check("full_if_pc", if_pc, 32'd124);
      check("full_halt_addr", mem_addr, 32'd31);
      check("addr_in_range", {31'd0, addr_over}, 32'd0);
      $display("test full_memory: count=%0d", fetch_count);

      // Reset pulsed mid-stall at if_pc=0x18.
      load(16);
      release_reset();
      for (int k = 0; k < 6; k++)
         step();
      expect_word("mr_at18", 6, 6);
      stall = 1'b1;
      step();
      expect_word("mr_stalled", 6, 6);
      reset = 1'b1;
      #1;
      check("mr_in_valid", {31'd0, if_valid}, 32'd0);
      check("mr_in_pc", if_pc, 32'd0);
      check("mr_in_addr", mem_addr, 32'd0);
      step();
      check("mr_count", {16'd0, fetch_count}, 32'd0);
      check("mr_halted", {31'd0, halted}, 32'd0);
      check("mr_pc", if_pc, 32'd0);
      reset = 1'b0;
      stall = 1'b0;
      #1;
      check("mr_boot_addr", mem_addr, 32'd0);
      check("mr_boot_valid", {31'd0, if_valid}, 32'd0);
      step();
      expect_word("mr_restart0", 0, 0);
      step();
      expect_word("mr_restart1", 1, 1);
      $display("test mid_reset: if_pc=%h count=%0d", if_pc, fetch_count);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
